// File: rtl/cipher_frame_packer_if.sv
// Byte-stream bundle between the cipher core, the frame packer and the link transmitter.
// The master modport is the packer's view; the slave modport is the environment's view.
interface cipher_frame_packer_if;
    logic [7:0] ciphertext;
    logic       valid_out;
    logic       flush;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    modport master (
        input  ciphertext, valid_out, flush, m_ready,
        output m_data, m_valid, m_last
    );

    modport slave (
        output ciphertext, valid_out, flush, m_ready,
        input  m_data, m_valid, m_last
    );
endinterface

// File: rtl/cipher_frame_packer.sv
// Buffers ciphertext bytes in a FIFO and emits [SOF, LEN, payload, CHK] frames on a
// valid/ready byte stream. A frame closes on MAX_LEN buffered bytes or on a pending flush.
module cipher_frame_packer #(
    parameter int         DEPTH   = 16,
    parameter int         MAX_LEN = 8,
    parameter logic [7:0] SOF     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cipher_frame_packer_if.master bus,
    output logic                  busy,
    output logic                  overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_PAY  = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;

    logic [2:0]    state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          flush_pend;
    logic [7:0]    len;
    logic [7:0]    rem;
    logic [7:0]    chk;

    logic          push;
    logic          pop;
    logic          accept;
    logic          start;
    logic [7:0]    head;
    logic [7:0]    len_next;
    logic [31:0]   count_w;

    // Space is judged on the registered count only, so a same-cycle pop never makes room.
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        count_w  = 32'(count);
        push     = bus.valid_out && (count < FULL);
        accept   = (state != S_IDLE) && bus.m_ready;
        pop      = accept && (state == S_PAY);
        head     = mem[rd_ptr];
        start    = (count_w >= 32'(MAX_LEN)) || (flush_pend && (count != '0));
        len_next = (count_w >= 32'(MAX_LEN)) ? 8'(MAX_LEN) : count_w[7:0];
    end

    // Outputs are decoded from registered state only; m_ready never reaches m_valid.
    always_comb begin
        bus.m_valid = (state != S_IDLE);
        bus.m_last  = (state == S_CHK);
        busy        = (state != S_IDLE);
        case (state)
            S_HDR:   bus.m_data = SOF;
            S_LEN:   bus.m_data = len;
            S_PAY:   bus.m_data = head;
            S_CHK:   bus.m_data = chk;
            default: bus.m_data = 8'h00;
        endcase
    end

    // NOTE: the storage array has no reset; clearing pointers and count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.ciphertext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (bus.valid_out && !push) begin
                overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A new flush wins over clearing, so a message end seen at frame start is not lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flush_pend <= 1'b0;
        end else if (bus.flush) begin
            flush_pend <= 1'b1;
        end else if ((state == S_IDLE) && (start || (count == '0))) begin
            flush_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            len   <= 8'h00;
            rem   <= 8'h00;
            chk   <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_HDR;
                        len   <= len_next;
                        chk   <= len_next;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        state <= S_PAY;
                        rem   <= len;
                    end
                end
                S_PAY: begin
                    if (accept) begin
                        chk <= chk ^ head;
                        rem <= rem - 8'd1;
                        if (rem == 8'd1) begin
                            state <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
